fp_twiddle_multiplier: RTL and testbench

FP_TWIDDLE_MULTIPLIER -- requirements
Module: fp_twiddle_multiplier

---
 rtl/fp_pkg.sv | 62 ++++++
 rtl/fp_mul_normalize.sv | 57 +++++
 rtl/fp_twiddle_multiplier.sv | 118 +++++++++++
 tb/tb_fp_twiddle_multiplier.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision helpers for the twiddle multiplier datapath:
// field widths, bias constants, unpacked-operand and stage payload types.
package fp_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int SIG_W      = 24;
  localparam int ESUM_W     = 10;
  localparam int PROD_W     = 48;
  localparam int WORD_W     = 32;

  // Final-exponent bounds used by the normaliser (signed 10-bit domain).
  localparam logic signed [ESUM_W-1:0] EXP_ZERO = 10'sd0;
  localparam logic signed [ESUM_W-1:0] EXP_OVF  = 10'sd255;
  localparam logic signed [ESUM_W-1:0] EXP_ONE  = 10'sd1;

  // One IEEE-754 operand split into its fields; sig carries the hidden bit.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [SIG_W-1:0]  sig;
    logic              exc;
  } fp_unpacked_t;

  // Payload held in the unpack stage register.
  typedef struct packed {
    logic                     sign;
    logic [SIG_W-1:0]         sig_a;
    logic [SIG_W-1:0]         sig_b;
    logic signed [ESUM_W-1:0] esum;
    logic                     exc;
  } fp_s1_t;

  // Payload held in the multiply stage register.
  typedef struct packed {
    logic                     sign;
    logic [PROD_W-1:0]        prod;
    logic signed [ESUM_W-1:0] esum;
    logic                     exc;
  } fp_s2_t;

  // Split a word into sign/exponent/significand; exponent 0 has no hidden bit.
  function automatic fp_unpacked_t fp_unpack(input logic [WORD_W-1:0] x);
    fp_unpacked_t u;
    u.sign = x[WORD_W-1];
    u.exp  = x[WORD_W-2:FRAC_W];
    u.sig  = {(|x[WORD_W-2:FRAC_W]), x[FRAC_W-1:0]};
    u.exc  = &x[WORD_W-2:FRAC_W];
    return u;
  endfunction

  // Biased exponent sum ea + eb - bias, wide enough to hold under/overflow.
  function automatic logic signed [ESUM_W-1:0] fp_exp_sum(input logic [EXP_W-1:0] ea,
                                                          input logic [EXP_W-1:0] eb);
    logic [ESUM_W-1:0] s;
    s = {2'b00, ea} + {2'b00, eb} - ESUM_W'(FP_BIAS);
    return $signed(s);
  endfunction

endpackage

// File: rtl/fp_mul_normalize.sv
// Combinational normalise/pack stage: turns the raw 48-bit significand
// product into a truncated single-precision word with flush-to-zero,
// overflow-to-infinity and exponent-255 input signalling.
module fp_mul_normalize
  import fp_pkg::*;
(
  input  logic [PROD_W-1:0]        i_prod,
  input  logic                     i_sign,
  input  logic signed [ESUM_W-1:0] i_esum,
  input  logic                     i_exc,
  output logic [WORD_W-1:0]        o_result,
  output logic                     o_exception
);

  logic [FRAC_W-1:0]        w_frac;
  logic signed [ESUM_W-1:0] w_exp;
  logic                     w_unused_lsbs;

  // Bits below the truncation point never reach the result.
  assign w_unused_lsbs = ^i_prod[FRAC_W-1:0];

  // Pick the fraction window under the leading one; a carry into bit 47 bumps the exponent.
  always_comb begin
    w_frac = '0;
    w_exp  = i_esum;
    if (i_prod[PROD_W-1]) begin
      w_frac = i_prod[PROD_W-2:PROD_W-1-FRAC_W];
      w_exp  = i_esum + EXP_ONE;
    end else begin
      w_frac = i_prod[PROD_W-3:PROD_W-2-FRAC_W];
      w_exp  = i_esum;
    end
  end

  // Classify the product and pack the output word.
  always_comb begin
    o_result    = 32'h0000_0000;
    o_exception = 1'b0;
    if (i_exc) begin
      o_result    = 32'h0000_0000;
      o_exception = 1'b1;
    end else if (i_prod[PROD_W-1:PROD_W-2] == 2'b00) begin
      o_result    = {i_sign, 31'd0};
      o_exception = 1'b0;
    end else if (w_exp <= EXP_ZERO) begin
      o_result    = {i_sign, 31'd0};
      o_exception = 1'b0;
    end else if (w_exp >= EXP_OVF) begin
      o_result    = {i_sign, 8'hFF, 23'd0};
      o_exception = 1'b1;
    end else begin
      o_result    = {i_sign, w_exp[EXP_W-1:0], w_frac};
      o_exception = 1'b0;
    end
  end

endmodule

// File: rtl/fp_twiddle_multiplier.sv
// Three-stage single-precision multiplier for FFT twiddle products:
// S1 unpack, S2 24x24 significand multiply, S3 normalise/pack.
// A single global advance keeps all stages frozen while the output is stalled.
module fp_twiddle_multiplier
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_operand,
  input  logic [WORD_W-1:0] b_operand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] result,
  output logic              exception
);

  logic              w_stall;
  logic              w_adv;
  logic              r_s1_valid;
  logic              r_s2_valid;
  logic              r_s3_valid;
  fp_unpacked_t      w_a;
  fp_unpacked_t      w_b;
  fp_s1_t            w_s1_next;
  fp_s1_t            r_s1;
  fp_s2_t            r_s2;
  logic [PROD_W-1:0] w_prod;
  logic [WORD_W-1:0] w_norm_result;
  logic              w_norm_exc;
  logic [WORD_W-1:0] r_result;
  logic              r_exception;

  assign w_stall   = r_s3_valid & ~out_ready;
  assign w_adv     = ~w_stall;
  assign in_ready  = w_adv;
  assign out_valid = r_s3_valid;
  assign result    = r_result;
  assign exception = r_exception;

  // Unpack both operands and form the stage-1 payload.
  always_comb begin
    w_a       = fp_unpack(a_operand);
    w_b       = fp_unpack(b_operand);
    w_s1_next = '0;
    w_s1_next.sign  = w_a.sign ^ w_b.sign;
    w_s1_next.sig_a = w_a.sig;
    w_s1_next.sig_b = w_b.sig;
    w_s1_next.esum  = fp_exp_sum(w_a.exp, w_b.exp);
    w_s1_next.exc   = w_a.exc | w_b.exc;
  end

  // Full-width unsigned significand product.
  assign w_prod = {{SIG_W{1'b0}}, r_s1.sig_a} * {{SIG_W{1'b0}}, r_s1.sig_b};

  // Stage valid bits shift together whenever the pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end else begin
      r_s1_valid <= r_s1_valid;
      r_s2_valid <= r_s2_valid;
      r_s3_valid <= r_s3_valid;
    end
  end

  // Stage-1 payload captures only real operand pairs (no reset needed).
  always_ff @(posedge clk) begin
    if (w_adv && in_valid) begin
      r_s1 <= w_s1_next;
    end else begin
      r_s1 <= r_s1;
    end
  end

  // Stage-2 payload captures the product of a valid stage-1 entry.
  always_ff @(posedge clk) begin
    if (w_adv && r_s1_valid) begin
      r_s2.sign <= r_s1.sign;
      r_s2.prod <= w_prod;
      r_s2.esum <= r_s1.esum;
      r_s2.exc  <= r_s1.exc;
    end else begin
      r_s2 <= r_s2;
    end
  end

  fp_mul_normalize u_norm (
    .i_prod      (r_s2.prod),
    .i_sign      (r_s2.sign),
    .i_esum      (r_s2.esum),
    .i_exc       (r_s2.exc),
    .o_result    (w_norm_result),
    .o_exception (w_norm_exc)
  );

  // Output register: loads a new product on advance, otherwise holds for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= 32'h0000_0000;
      r_exception <= 1'b0;
    end else if (w_adv && r_s2_valid) begin
      r_result    <= w_norm_result;
      r_exception <= w_norm_exc;
    end else begin
      r_result    <= r_result;
      r_exception <= r_exception;
    end
  end

endmodule

// File: tb/tb_fp_twiddle_multiplier.sv
// Self-checking bench for fp_twiddle_multiplier: directed vectors, backpressure,
// mid-flight reset and a randomized stream against a real-arithmetic model.
module tb_fp_twiddle_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        exception;

  int          n_checks;
  int          n_errors;
  int          n_stall;
  int          n_popped;
  bit          rand_done;
  logic [32:0] exp_q[$];

  fp_twiddle_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exception (exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    logic [63:0] t;
    t = {1'b0, 11'(k + 1023), 52'd0};
    return $bitstoreal(t);
  endfunction

  // Reference: exact product in double precision, then truncate to single fields.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    longint      sa, sb, p;
    real         prod;
    logic [63:0] bits;
    logic        s;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b1, 32'h0000_0000};
    sa = longint'(a[22:0]);
    sb = longint'(b[22:0]);
    if (ea != 0) sa += 64'sd8388608;
    if (eb != 0) sb += 64'sd8388608;
    p = sa * sb;
    if (p < 64'sd70368744177664) return {1'b0, s, 31'd0};
    prod = real'(p) * pow2(ea + eb - 300);
    bits = $realtobits(prod);
    e    = int'(bits[62:52]) - 1023 + 127;
    if (e <= 0)   return {1'b0, s, 31'd0};
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    return {1'b0, s, 8'(e), bits[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    int          sel;
    x   = $urandom;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       x[30:23] = 8'd0;
      1:       x[30:23] = 8'd255;
      2:       x[30:23] = 8'($urandom_range(1, 20));
      3:       x[30:23] = 8'($urandom_range(230, 254));
      4, 5, 6: x[30:23] = 8'($urandom_range(100, 154));
      default: ;
    endcase
    return x;
  endfunction

  // Scoreboard monitor: samples handshakes on the falling edge.
  initial begin
    logic [32:0] held;
    bit          was_stall;
    was_stall = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        was_stall = 1'b0;
      end else begin
        if (was_stall && out_valid) chk("stall_hold", {exception, result}, held);
        if (in_valid && in_ready) exp_q.push_back(model(a_operand, b_operand));
        if (out_valid && !out_ready) begin
          chk("in_ready_stall", in_ready, 1'b0);
          held      = {exception, result};
          was_stall = 1'b1;
          n_stall++;
        end else begin
          was_stall = 1'b0;
        end
        if (out_valid && out_ready) begin
          n_popped++;
          if (exp_q.size() == 0) chk("spurious_out", 1'b1, 1'b0);
          else chk("product", {exception, result}, exp_q.pop_front());
        end
      end
    end
  end

  // Present a pair until accepted; called just after a rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int tries;
    bit acc;
    tries     = 0;
    acc       = 1'b0;
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
      if (!acc && tries > 50) begin
        chk("send_timeout", 1'b0, 1'b1);
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee);
    int k;
    k = 0;
    send(a, b);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        k = i;
        break;
      end
    end
    chk({tag, "_lat"}, k, 3);
    chk({tag, "_res"}, result, er);
    chk({tag, "_exc"}, exception, ee);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int base_pop;
    int base_stall;
    int seen;
    n_checks  = 0;
    n_errors  = 0;
    n_stall   = 0;
    n_popped  = 0;
    rand_done = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_operand = 32'h0;
    b_operand = 32'h0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 32'h0);
    chk("rst_exception", exception, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec("mul_2x3",   32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);
    run_vec("mul_15x15", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
    run_vec("mul_neg",   32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000, 1'b0);
    run_vec("exc_inf",   32'h7F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1);
    run_vec("overflow",  32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1);
    run_vec("underflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0);
    run_vec("neg_zero",  32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0);

    // Backpressure: eight back-to-back pairs with a five-cycle consumer stall.
    base_pop   = n_popped;
    base_stall = n_stall;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_fp(), rand_fp());
      end
      begin
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", n_popped - base_pop, 8);
    chk("bp_stall_cycles", n_stall - base_stall, 5);

    // Reset with three products in flight.
    for (int i = 0; i < 3; i++) send(rand_fp(), rand_fp());
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_result", {exception, result}, 33'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_stale", seen, 0);
    @(posedge clk);
    #1;
    run_vec("post_rst", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);

    // Randomized stream with random gaps and random consumer readiness.
    base_pop = n_popped;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_fp(), rand_fp());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain");
    chk("rand_count", n_popped - base_pop, 300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
